dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and the word-serial main-memory port. It answers CPU loads and stores on a hit in the same cycle. On a miss it raises DCacheMiss, which the hazard unit consumes to stall the whole pipeline, and holds it until the access can complete as a hit. While DCacheMiss is high, the cache writes back the dirty victim line and refills the new line word by word.

Parameters:
LINE_ADDR_LEN, 3, log2 of words per line (default 8 words).
SET_ADDR_LEN, 3, log2 of number of lines (default 8 sets).
TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN, tag width (derived, not overridden).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
RdReq  in  1  load request from MEM stage
WrReq  in  1  store request from MEM stage
Addr  in  32  byte address; bits [1:0] ignored (word access only)
WrData  in  32  store data
RdData  out  32  load data; valid in the hit cycle
DCacheMiss  out  1  to hazard unit; 1 = stall pipeline
MemReq  out  1  memory word request, held until MemAck
MemWe  out  1  1 = write word, 0 = read word
MemAddr  out  32  byte address of the memory word
MemWData  out  32  write-back word
MemRData  in  32  refill word, valid when MemAck=1
MemAck  in  1  one-cycle completion pulse per word
MissCnt  out  32  saturating count of misses

Behaviour:
- Address split: offset = Addr[LINE_ADDR_LEN+1:2]; set = next SET_ADDR_LEN bits; tag = Addr[31:32-TAG_ADDR_LEN].
- Storage: data array, tag array, valid bit and dirty bit per line. Valid, dirty, FSM state, counters, MissCnt and all Mem* outputs reset to 0. Data and tag arrays are not reset.
- Hit: valid[set] && tag match.
- Request: Req = RdReq | WrReq. If both are asserted, the access is a store; RdData still shows the old word.
- DCacheMiss is combinational: (Req && !hit) || state != IDLE. It is 0 after reset with no request.
- RdData = hit && RdReq ? word : 0.
- Store hit: the word is written and dirty set at the clk edge of the hit cycle.
- FSM states:
  - IDLE: on Req && !hit, latch Addr into MissAddr and increment MissCnt (saturates at 0xFFFFFFFF). Go to WB if valid && dirty, else REFILL.
  - WB: MemReq=1, MemWe=1, MemAddr = {old tag, set, cnt, 2'b00}, MemWData = line[cnt]. On MemAck, cnt++. On the last word, cnt=0 and go to REFILL.
  - REFILL: MemReq=1, MemWe=0, MemAddr = {MissAddr line base, cnt, 2'b00}. On MemAck, line[cnt] = MemRData and cnt++. On the last word, write the tag, set valid=1 and dirty=0, then go to IDLE.
  - IDLE (following cycle): the held request now hits, DCacheMiss falls, and a store completes as a store hit.
- Miss latency: (#WB words + #refill words) × memory latency + 1 hit cycle.
- Mem* outputs are registered and change only on clk edges. MemReq drops in the cycle after the final MemAck. MemAck while MemReq=0 is ignored.
- The CPU holds RdReq, WrReq, Addr and WrData stable while DCacheMiss=1. The cache uses only MissAddr during WB and REFILL.
- Reset mid-operation: rst_n low immediately clears MemReq, MemWe, state, cnt and valid. A partial line is never marked valid.
- cnt wraps to 0 after 2^LINE_ADDR_LEN−1. There is no partial-line transfer.

Test Plan:
1. Reset, then RdReq with Addr=0x40 → DCacheMiss=1 in the same cycle; 8 reads at 0x40..0x5C with no MemWe; then 1 hit cycle with RdData=mem[0x40], DCacheMiss=0, MissCnt=1.
2. Continuing from test 1, RdReq with Addr=0x44 → DCacheMiss=0 in the request cycle; RdData=mem[0x44]; MissCnt stays 1.
3. WrReq with Addr=0x48 and WrData=0xDEADBEEF (hit), then RdReq with Addr=0x148 → write-back of 0x40..0x5C with the word at 0x48 = 0xDEADBEEF; refill of 0x140..0x15C; RdData=mem[0x148]; MissCnt=2.
4. WrReq with Addr=0x200 and WrData=0x12345678 (clean miss, set 0) → refill of 0x200..0x21C; store applies in the hit cycle; next RdReq at 0x200 hits and returns 0x12345678.
5. Random MemAck latency of 0–5 cycles during tests 1–4 → identical data and address sequences; MemReq never drops before its ack.
6. rst_n pulsed low after the 3rd refill ack → MemReq=0 asynchronously; the next RdReq at 0x40 misses again with a full 8-word refill starting at 0x40.

Source files
------------

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache; hits answer in the request cycle.
// Misses hold DCacheMiss while the dirty victim is written back and the line refilled one word per MemAck.
module dcache_wb #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RdReq,
  input  logic        WrReq,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        DCacheMiss,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic [31:0] MissCnt
);

  localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
  localparam int SETS       = 1 << SET_ADDR_LEN;
  localparam int BASE_W     = 32 - 2 - LINE_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  logic [31:0]             data_arr [SETS][LINE_WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_arr  [SETS];
  logic [SETS-1:0]         valid;
  logic [SETS-1:0]         dirty;

  state_t                   state;
  logic [LINE_ADDR_LEN-1:0] cnt;
  logic [LINE_ADDR_LEN-1:0] cnt_nxt;
  logic [BASE_W-1:0]        miss_line;

  logic [LINE_ADDR_LEN-1:0] off;
  logic [SET_ADDR_LEN-1:0]  set;
  logic [TAG_ADDR_LEN-1:0]  tag;
  logic [SET_ADDR_LEN-1:0]  m_set;
  logic [TAG_ADDR_LEN-1:0]  m_tag;
  logic                     req;
  logic                     hit;
  logic                     ack;
  logic                     last;
  logic                     store_hit;
  logic                     refill_wr;
  logic                     refill_done;
  logic                     unused_addr;

  assign off   = Addr[LINE_ADDR_LEN+1:2];
  assign set   = Addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign tag   = Addr[31:32-TAG_ADDR_LEN];
  assign m_set = miss_line[SET_ADDR_LEN-1:0];
  assign m_tag = miss_line[BASE_W-1:SET_ADDR_LEN];
  assign unused_addr = ^Addr[1:0];

  assign req         = RdReq | WrReq;
  assign hit         = valid[set] && (tag_arr[set] == tag);
  assign ack         = MemAck && MemReq;
  assign last        = &cnt;
  assign cnt_nxt     = cnt + LINE_ADDR_LEN'(1);
  assign store_hit   = (state == IDLE) && WrReq && hit;
  assign refill_wr   = (state == REFILL) && ack;
  assign refill_done = refill_wr && last;

  assign DCacheMiss = (req && !hit) || (state != IDLE);
  assign RdData     = (hit && RdReq) ? data_arr[set][off] : 32'd0;

  // Arrays carry no reset; valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (refill_wr)
      data_arr[m_set][cnt] <= MemRData;
    else if (store_hit)
      data_arr[set][off] <= WrData;
    if (refill_done)
      tag_arr[m_set] <= m_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      miss_line <= '0;
      valid     <= '0;
      dirty     <= '0;
      MissCnt   <= '0;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit)
            dirty[set] <= 1'b1;
          if (req && !hit) begin
            miss_line <= Addr[31:LINE_ADDR_LEN+2];
            cnt       <= '0;
            MemReq    <= 1'b1;
            if (MissCnt != 32'hFFFF_FFFF)
              MissCnt <= MissCnt + 32'd1;
            if (valid[set] && dirty[set]) begin
              state    <= WB;
              MemWe    <= 1'b1;
              MemAddr  <= {tag_arr[set], set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
              MemWData <= data_arr[set][0];
            end else begin
              // Drop valid before overwriting so a partly refilled line can never hit.
              state      <= REFILL;
              valid[set] <= 1'b0;
              MemWe      <= 1'b0;
              MemAddr    <= {Addr[31:LINE_ADDR_LEN+2], {LINE_ADDR_LEN{1'b0}}, 2'b00};
            end
          end
        end
        WB: begin
          if (ack) begin
            if (last) begin
              cnt          <= '0;
              state        <= REFILL;
              valid[m_set] <= 1'b0;
              MemWe        <= 1'b0;
              MemAddr      <= {miss_line, {LINE_ADDR_LEN{1'b0}}, 2'b00};
            end else begin
              cnt      <= cnt_nxt;
              MemAddr  <= {tag_arr[m_set], m_set, cnt_nxt, 2'b00};
              MemWData <= data_arr[m_set][cnt_nxt];
            end
          end
        end
        REFILL: begin
          if (ack) begin
            if (last) begin
              cnt          <= '0;
              state        <= IDLE;
              valid[m_set] <= 1'b1;
              dirty[m_set] <= 1'b0;
              MemReq       <= 1'b0;
            end else begin
              cnt     <= cnt_nxt;
              MemAddr <= {miss_line, cnt_nxt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: word-serial memory model with random 0-5 cycle ack latency,
// transfer log, and hand-computed expected words (memory word at byte a starts as 0x10000000 + a).
module tb_dcache_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RdReq = 1'b0;
  logic        WrReq = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WrData = '0;
  logic [31:0] RdData;
  logic        DCacheMiss;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;
  logic [31:0] MissCnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];
  logic [31:0] log_addr [$];
  logic [31:0] log_dat  [$];
  logic        log_we   [$];
  int          rd_cnt = 0;
  int          drop_err = 0;
  int          wait_cnt = 0;
  logic        outstanding = 1'b0;

  dcache_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RdReq      (RdReq),
    .WrReq      (WrReq),
    .Addr       (Addr),
    .WrData     (WrData),
    .RdData     (RdData),
    .DCacheMiss (DCacheMiss),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .MemAck     (MemAck),
    .MissCnt    (MissCnt)
  );

  always #5 clk = ~clk;

  // Memory model: acts on negedges, one ack pulse per word, random wait before each ack.
  initial begin : memory
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    wait_cnt = $urandom_range(0, 5);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        MemAck      = 1'b0;
        outstanding = 1'b0;
      end else if (MemAck) begin
        MemAck = 1'b0;
      end else if (MemReq) begin
        if (wait_cnt == 0) begin
          if (MemWe) begin
            mem[MemAddr[9:2]] = MemWData;
            log_dat.push_back(MemWData);
          end else begin
            MemRData = mem[MemAddr[9:2]];
            log_dat.push_back(MemRData);
            rd_cnt++;
          end
          log_addr.push_back(MemAddr);
          log_we.push_back(MemWe);
          MemAck      = 1'b1;
          outstanding = 1'b0;
          wait_cnt    = $urandom_range(0, 5);
        end else begin
          wait_cnt--;
          outstanding = 1'b1;
        end
      end else if (outstanding) begin
        drop_err++;
        outstanding = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_hit(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (DCacheMiss && n < 300);
    chk({tag, "_miss_clears"}, {31'd0, DCacheMiss}, 32'd0);
  endtask

  // Eight logged words from index base: address a0+4i, direction we, data defaulting to 0x10000000+a.
  task automatic check_xfer(input string tag, input int base, input logic we,
                            input logic [31:0] a0, input logic [31:0] paddr, input logic [31:0] pdat);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = a0 + 32'(i * 4);
      d = (a == paddr) ? pdat : 32'h1000_0000 + a;
      if (base + i < log_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), log_addr[base+i], a);
        chk($sformatf("%s_we%0d", tag, i), {31'd0, log_we[base+i]}, {31'd0, we});
        chk($sformatf("%s_dat%0d", tag, i), log_dat[base+i], d);
      end else begin
        chk($sformatf("%s_present%0d", tag, i), 32'(log_addr.size()), 32'(base + i + 1));
      end
    end
  endtask

  initial begin : global_timeout
    #400000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1);
  end

  initial begin : stimulus
    int base;
    int base_rd;
    int n;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_miss", {31'd0, DCacheMiss}, 32'd0);
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_misscnt", MissCnt, 32'd0);
    chk("rst_rddata", RdData, 32'd0);

    // Cold read miss at 0x40: clean refill of 0x40..0x5C.
    @(posedge clk); #1;
    base = log_addr.size();
    RdReq = 1'b1; Addr = 32'h40;
    #1 chk("t1_miss_now", {31'd0, DCacheMiss}, 32'd1);
    wait_hit("t1");
    chk("t1_rddata", RdData, 32'h1000_0040);
    chk("t1_misscnt", MissCnt, 32'd1);
    chk("t1_len", 32'(log_addr.size()), 32'(base + 8));
    check_xfer("t1", base, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'd0);

    // Read hit in the same line.
    @(posedge clk); #1 Addr = 32'h44;
    @(negedge clk);
    chk("t2_miss", {31'd0, DCacheMiss}, 32'd0);
    chk("t2_rddata", RdData, 32'h1000_0044);
    chk("t2_misscnt", MissCnt, 32'd1);

    // Store hit dirties the line, then a conflicting read forces write-back.
    @(posedge clk); #1 RdReq = 1'b0; WrReq = 1'b1; Addr = 32'h48; WrData = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_store_miss", {31'd0, DCacheMiss}, 32'd0);
    chk("t3_store_rddata", RdData, 32'd0);
    @(posedge clk); #1;
    base = log_addr.size();
    WrReq = 1'b0; RdReq = 1'b1; Addr = 32'h148;
    wait_hit("t3");
    chk("t3_rddata", RdData, 32'h1000_0148);
    chk("t3_misscnt", MissCnt, 32'd2);
    chk("t3_len", 32'(log_addr.size()), 32'(base + 16));
    check_xfer("t3wb", base, 1'b1, 32'h40, 32'h48, 32'hDEAD_BEEF);
    check_xfer("t3rf", base + 8, 1'b0, 32'h140, 32'hFFFF_FFFF, 32'd0);

    // Store miss to empty set 0: refill, then the store lands in the hit cycle.
    @(posedge clk); #1;
    base = log_addr.size();
    RdReq = 1'b0; WrReq = 1'b1; Addr = 32'h200; WrData = 32'h1234_5678;
    wait_hit("t4");
    chk("t4_misscnt", MissCnt, 32'd3);
    chk("t4_len", 32'(log_addr.size()), 32'(base + 8));
    check_xfer("t4", base, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1 WrReq = 1'b0; RdReq = 1'b1;
    @(negedge clk);
    chk("t4_rd_miss", {31'd0, DCacheMiss}, 32'd0);
    chk("t4_rddata", RdData, 32'h1234_5678);
    chk("t4_misscnt_hold", MissCnt, 32'd3);

    // Read and write together: store wins, RdData shows the old word.
    @(posedge clk); #1 WrReq = 1'b1; Addr = 32'h204; WrData = 32'hCAFE_F00D;
    @(negedge clk);
    chk("both_rddata_old", RdData, 32'h1000_0204);
    @(posedge clk); #1 WrReq = 1'b0;
    @(negedge clk);
    chk("both_rddata_new", RdData, 32'hCAFE_F00D);

    // Reset during a refill, after its third word.
    @(posedge clk); #1;
    base_rd = rd_cnt;
    Addr = 32'h40;
    n = 0;
    while (rd_cnt < base_rd + 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("t6_acks_before_rst", 32'(rd_cnt - base_rd), 32'd3);
    #1 rst_n = 1'b0; RdReq = 1'b0;
    #1;
    chk("t6_rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("t6_rst_miss", {31'd0, DCacheMiss}, 32'd0);
    chk("t6_rst_misscnt", MissCnt, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    base = log_addr.size();
    RdReq = 1'b1; Addr = 32'h40;
    #1 chk("t6_miss_now", {31'd0, DCacheMiss}, 32'd1);
    wait_hit("t6");
    chk("t6_rddata", RdData, 32'h1000_0040);
    chk("t6_misscnt", MissCnt, 32'd1);
    chk("t6_len", 32'(log_addr.size()), 32'(base + 8));
    check_xfer("t6", base, 1'b0, 32'h40, 32'h48, 32'hDEAD_BEEF);

    @(posedge clk); #1 RdReq = 1'b0;
    @(negedge clk);
    chk("memreq_held_to_ack", 32'(drop_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
